// File: rtl/countdown_timer_if.sv
// rtl/countdown_timer_if.sv - control strobes and status outputs of the countdown timer
interface countdown_timer_if;
  logic       load;
  logic [3:0] load_value;
  logic       start;
  logic       pause;
  logic [3:0] counter;
  logic       running;
  logic       expired;
  logic       alarm;

  modport master (
    output load, load_value, start, pause,
    input  counter, running, expired, alarm
  );

  modport slave (
    input  load, load_value, start, pause,
    output counter, running, expired, alarm
  );
endinterface

// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - 4-bit prescaled countdown timer with expiry pulse and sticky alarm
// Optional feature: COUNTDOWN_AUTO_RELOAD_EN reloads the start value on expiry instead of stopping.
module countdown_timer #(
  parameter int unsigned TICKS_PER_STEP = 50000000
) (
  input  logic             clk,
  input  logic             reset,
  countdown_timer_if.slave bus
);
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSED, ST_EXPIRED} state_e;

  localparam logic [31:0] TERM = 32'(TICKS_PER_STEP - 1);

  state_e      state_q, state_d;
  logic [3:0]  counter_q, counter_d;
  logic [31:0] presc_q, presc_d;
  logic        expired_q, expired_d;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [3:0]  reload_q, reload_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      counter_q <= 4'd0;
      presc_q   <= 32'd0;
      expired_q <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      reload_q  <= 4'd0;
`endif
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      presc_q   <= presc_d;
      expired_q <= expired_d;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      reload_q  <= reload_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    presc_d   = presc_q;
    expired_d = 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    reload_d  = reload_q;
`endif
    if (bus.load) begin
      state_d   = ST_IDLE;
      counter_d = bus.load_value;
      presc_d   = 32'd0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      reload_d  = bus.load_value;
`endif
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          // pause on the same edge suppresses start even where pause itself does nothing
          if (bus.start && !bus.pause && counter_q != 4'd0) begin
            state_d = ST_RUN;
            presc_d = 32'd0;
          end
        end
        ST_RUN: begin
          if (bus.pause) begin
            state_d = ST_PAUSED;
          end else if (presc_q == TERM) begin
            presc_d = 32'd0;
            if (counter_q == 4'd1) begin
              expired_d = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
              if (reload_q != 4'd0) begin
                counter_d = reload_q;
              end else begin
                counter_d = 4'd0;
                state_d   = ST_EXPIRED;
              end
`else
              counter_d = 4'd0;
              state_d   = ST_EXPIRED;
`endif
            end else if (counter_q != 4'd0) begin
              counter_d = counter_q - 4'd1;
            end
          end else begin
            presc_d = presc_q + 32'd1;
          end
        end
        ST_PAUSED: begin
          if (bus.start && !bus.pause) begin
            state_d = ST_RUN;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // alarm is simply residency in EXPIRED, which only load or reset can leave
  always_comb begin
    bus.counter = counter_q;
    bus.running = (state_q == ST_RUN);
    bus.expired = expired_q;
    bus.alarm   = (state_q == ST_EXPIRED);
  end
endmodule
